// File: rtl/mips_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_control_unit                                            |
// | Description : Multicycle Moore control FSM for the multicycle MIPS         |
// |               datapath. It decodes Opcode/Funct from the instruction       |
// |               register and the ALU flags, and sources every mux select,    |
// |               register load strobe, memory strobe and ALU function code.   |
// |                                                                            |
// | Parameters  : MEM_WAIT (0..7) - extra memory cycles; FETCH and MEM_READ    |
// |               each last MEM_WAIT+1 cycles.                                 |
// | Option      : MIPS_CTRL_EXCEPTION_EN - when defined, invalid instructions  |
// |               and arithmetic overflow divert to state EXC (EPC load and    |
// |               jump to the exception vector). When undefined, INVALID is a  |
// |               one-cycle no-op, overflow is ignored and EPC_load is 0.      |
// |                                                                            |
// | Ports       : Clk, Reset_n (async, active low)                             |
// |               Opcode[5:0], Funct[5:0]  - IR fields                         |
// |               ALU_zero, ALU_overflow   - ALU flags                         |
// |               PC_load, IorD, wr, MemtoReg, IR_load, MDR_load, RegWrite,    |
// |               RegDst, ALUSrcA, ALUSrcB[1:0], ALU_sel[2:0], PCSource[1:0],  |
// |               A_load, B_load, ALUOut_load, EPC_load - datapath controls    |
// |               State[3:0] - current state, for debug/trace                  |
// |                                                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_control_unit #(
   parameter int MEM_WAIT = 1
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       ALU_zero,
   input  logic       ALU_overflow,
   output logic       PC_load,
   output logic       IorD,
   output logic       wr,
   output logic       MemtoReg,
   output logic       IR_load,
   output logic       MDR_load,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALU_sel,
   output logic [1:0] PCSource,
   output logic       A_load,
   output logic       B_load,
   output logic       ALUOut_load,
   output logic       EPC_load,
   output logic [3:0] State
);

   // ------------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------------
   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_J     = 6'h02;
   localparam logic [5:0] c_OP_BEQ   = 6'h04;
   localparam logic [5:0] c_OP_BNE   = 6'h05;
   localparam logic [5:0] c_OP_ADDI  = 6'h08;
   localparam logic [5:0] c_OP_LW    = 6'h23;
   localparam logic [5:0] c_OP_SW    = 6'h2B;

   localparam logic [5:0] c_FN_ADD   = 6'h20;
   localparam logic [5:0] c_FN_SUB   = 6'h22;
   localparam logic [5:0] c_FN_AND   = 6'h24;
   localparam logic [5:0] c_FN_XOR   = 6'h26;
   localparam logic [5:0] c_FN_SLT   = 6'h2A;

   localparam logic [2:0] c_ALU_PASS = 3'b000;
   localparam logic [2:0] c_ALU_ADD  = 3'b001;
   localparam logic [2:0] c_ALU_SUB  = 3'b010;
   localparam logic [2:0] c_ALU_AND  = 3'b011;
   localparam logic [2:0] c_ALU_XOR  = 3'b110;
   localparam logic [2:0] c_ALU_CMP  = 3'b111;

   // Wait count value that marks the last cycle of a memory access state
   localparam logic [2:0] c_WAIT_LAST = 3'(MEM_WAIT);

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_R_EXEC    = 4'd3,
      S_R_WB      = 4'd4,
      S_MEM_ADDR  = 4'd5,
      S_MEM_READ  = 4'd6,
      S_LOAD_WB   = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12,
      S_INVALID   = 4'd13
`ifdef MIPS_CTRL_EXCEPTION_EN
      ,
      S_EXC       = 4'd14
`endif
   } state_t;

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   state_t     r_state;
   logic [2:0] r_wait_cnt;
   logic       r_pc_write;
   logic       r_pc_write_cond;
   logic       r_branch_ne;
   logic       r_iord;
   logic       r_wr;
   logic       r_mem_to_reg;
   logic       r_ir_load;
   logic       r_mdr_load;
   logic       r_reg_write;
   logic       r_reg_dst;
   logic       r_alu_src_a;
   logic [1:0] r_alu_src_b;
   logic [2:0] r_alu_sel;
   logic [1:0] r_pc_source;
   logic       r_a_load;
   logic       r_b_load;
   logic       r_aluout_load;
`ifdef MIPS_CTRL_EXCEPTION_EN
   logic       r_epc_load;
`endif

   // ------------------------------------------------------------------------
   // Combinational next-state and next-output decode
   // ------------------------------------------------------------------------
   state_t     w_next_state;
   logic [2:0] w_next_wait;
   logic       w_wait_done;
   logic       w_next_last;
   logic       w_funct_ok;
   logic       w_funct_addsub;
   logic [2:0] w_funct_sel;

   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_branch_ne;
   logic       w_iord;
   logic       w_wr;
   logic       w_mem_to_reg;
   logic       w_ir_load;
   logic       w_mdr_load;
   logic       w_reg_write;
   logic       w_reg_dst;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [2:0] w_alu_sel;
   logic [1:0] w_pc_source;
   logic       w_a_load;
   logic       w_b_load;
   logic       w_aluout_load;
   logic       w_epc_load;

   assign w_wait_done = (r_wait_cnt == c_WAIT_LAST);

   // R-type function decode; unknown Funct values make the instruction invalid
   always_comb begin
      w_funct_ok     = 1'b1;
      w_funct_addsub = 1'b0;
      w_funct_sel    = c_ALU_PASS;
      case (Funct)
         c_FN_ADD: begin w_funct_sel = c_ALU_ADD; w_funct_addsub = 1'b1; end
         c_FN_SUB: begin w_funct_sel = c_ALU_SUB; w_funct_addsub = 1'b1; end
         c_FN_AND: w_funct_sel = c_ALU_AND;
         c_FN_XOR: w_funct_sel = c_ALU_XOR;
         c_FN_SLT: w_funct_sel = c_ALU_CMP;
         default:  w_funct_ok  = 1'b0;
      endcase
   end

`ifndef MIPS_CTRL_EXCEPTION_EN
   // Overflow has no consumer when exceptions are compiled out
   logic [1:0] w_unused_ovf;
   assign w_unused_ovf = {ALU_overflow, w_funct_addsub};
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_RESET:  w_next_state = S_FETCH;
         S_FETCH:  if (w_wait_done) w_next_state = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               c_OP_RTYPE:         w_next_state = S_R_EXEC;
               c_OP_LW, c_OP_SW:   w_next_state = S_MEM_ADDR;
               c_OP_BEQ, c_OP_BNE: w_next_state = S_BRANCH;
               c_OP_ADDI:          w_next_state = S_ADDI_EXEC;
               c_OP_J:             w_next_state = S_JUMP;
               default:            w_next_state = S_INVALID;
            endcase
         end
         S_R_EXEC: begin
            if (!w_funct_ok)
               w_next_state = S_INVALID;
`ifdef MIPS_CTRL_EXCEPTION_EN
            else if (w_funct_addsub && ALU_overflow)
               w_next_state = S_EXC;
`endif
            else
               w_next_state = S_R_WB;
         end
         S_MEM_ADDR:  w_next_state = (Opcode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (w_wait_done) w_next_state = S_LOAD_WB;
         S_ADDI_EXEC: begin
`ifdef MIPS_CTRL_EXCEPTION_EN
            if (ALU_overflow)
               w_next_state = S_EXC;
            else
`endif
               w_next_state = S_ADDI_WB;
         end
`ifdef MIPS_CTRL_EXCEPTION_EN
         S_INVALID:   w_next_state = S_EXC;
`else
         S_INVALID:   w_next_state = S_FETCH;
`endif
         default:     w_next_state = S_FETCH;
      endcase
   end

   // Counter restarts on every state change; only the wait states self-loop
   assign w_next_wait = (w_next_state != r_state) ? 3'd0 : (r_wait_cnt + 3'd1);
   assign w_next_last = (w_next_wait == c_WAIT_LAST);

   // Outputs are decoded for the state being entered and then registered, so
   // the output registers always reflect the current state.
   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_branch_ne     = 1'b0;
      w_iord          = 1'b0;
      w_wr            = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_ir_load       = 1'b0;
      w_mdr_load      = 1'b0;
      w_reg_write     = 1'b0;
      w_reg_dst       = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_alu_sel       = c_ALU_PASS;
      w_pc_source     = 2'b00;
      w_a_load        = 1'b0;
      w_b_load        = 1'b0;
      w_aluout_load   = 1'b0;
      w_epc_load      = 1'b0;
      case (w_next_state)
         S_FETCH: begin
            w_alu_src_b = 2'b01;
            w_alu_sel   = c_ALU_ADD;
            if (w_next_last) begin
               w_ir_load  = 1'b1;
               w_pc_write = 1'b1;
            end
         end
         S_DECODE: begin
            w_alu_src_b   = 2'b11;
            w_alu_sel     = c_ALU_ADD;
            w_a_load      = 1'b1;
            w_b_load      = 1'b1;
            w_aluout_load = 1'b1;
         end
         S_R_EXEC: begin
            w_alu_src_a   = 1'b1;
            w_alu_sel     = w_funct_sel;
            w_aluout_load = 1'b1;
         end
         S_R_WB: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            w_alu_src_a   = 1'b1;
            w_alu_src_b   = 2'b10;
            w_alu_sel     = c_ALU_ADD;
            w_aluout_load = 1'b1;
         end
         S_MEM_READ: begin
            w_iord     = 1'b1;
            w_mdr_load = w_next_last;
         end
         S_LOAD_WB: begin
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            w_iord = 1'b1;
            w_wr   = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_sel       = c_ALU_SUB;
            w_pc_source     = 2'b01;
            w_pc_write_cond = 1'b1;
            w_branch_ne     = (Opcode == c_OP_BNE);
         end
         S_JUMP: begin
            w_pc_source = 2'b10;
            w_pc_write  = 1'b1;
         end
         S_ADDI_WB: w_reg_write = 1'b1;
`ifdef MIPS_CTRL_EXCEPTION_EN
         S_EXC: begin
            // ALU forms PC-4 (PC already advanced in FETCH) for the EPC
            w_alu_src_b = 2'b01;
            w_alu_sel   = c_ALU_SUB;
            w_epc_load  = 1'b1;
            w_pc_source = 2'b11;
            w_pc_write  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register; reset clears every strobe immediately
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state         <= S_RESET;
         r_wait_cnt      <= 3'd0;
         r_pc_write      <= 1'b0;
         r_pc_write_cond <= 1'b0;
         r_branch_ne     <= 1'b0;
         r_iord          <= 1'b0;
         r_wr            <= 1'b0;
         r_mem_to_reg    <= 1'b0;
         r_ir_load       <= 1'b0;
         r_mdr_load      <= 1'b0;
         r_reg_write     <= 1'b0;
         r_reg_dst       <= 1'b0;
         r_alu_src_a     <= 1'b0;
         r_alu_src_b     <= 2'b00;
         r_alu_sel       <= 3'b000;
         r_pc_source     <= 2'b00;
         r_a_load        <= 1'b0;
         r_b_load        <= 1'b0;
         r_aluout_load   <= 1'b0;
`ifdef MIPS_CTRL_EXCEPTION_EN
         r_epc_load      <= 1'b0;
`endif
      end else begin
         r_state         <= w_next_state;
         r_wait_cnt      <= w_next_wait;
         r_pc_write      <= w_pc_write;
         r_pc_write_cond <= w_pc_write_cond;
         r_branch_ne     <= w_branch_ne;
         r_iord          <= w_iord;
         r_wr            <= w_wr;
         r_mem_to_reg    <= w_mem_to_reg;
         r_ir_load       <= w_ir_load;
         r_mdr_load      <= w_mdr_load;
         r_reg_write     <= w_reg_write;
         r_reg_dst       <= w_reg_dst;
         r_alu_src_a     <= w_alu_src_a;
         r_alu_src_b     <= w_alu_src_b;
         r_alu_sel       <= w_alu_sel;
         r_pc_source     <= w_pc_source;
         r_a_load        <= w_a_load;
         r_b_load        <= w_b_load;
         r_aluout_load   <= w_aluout_load;
`ifdef MIPS_CTRL_EXCEPTION_EN
         r_epc_load      <= w_epc_load;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Output assignments
   // ------------------------------------------------------------------------
   // Branch condition is the only combinational path from an input
   assign PC_load     = r_pc_write | (r_pc_write_cond & (r_branch_ne ? ~ALU_zero : ALU_zero));
   assign IorD        = r_iord;
   assign wr          = r_wr;
   assign MemtoReg    = r_mem_to_reg;
   assign IR_load     = r_ir_load;
   assign MDR_load    = r_mdr_load;
   assign RegWrite    = r_reg_write;
   assign RegDst      = r_reg_dst;
   assign ALUSrcA     = r_alu_src_a;
   assign ALUSrcB     = r_alu_src_b;
   assign ALU_sel     = r_alu_sel;
   assign PCSource    = r_pc_source;
   assign A_load      = r_a_load;
   assign B_load      = r_b_load;
   assign ALUOut_load = r_aluout_load;
   assign State       = r_state;
`ifdef MIPS_CTRL_EXCEPTION_EN
   assign EPC_load    = r_epc_load;
`else
   assign EPC_load    = 1'b0;
   logic w_unused_epc;
   assign w_unused_epc = w_epc_load;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips_control_unit                                         |
// | Description : Directed self-checking bench for mips_control_unit with      |
// |               MEM_WAIT=1. Each cycle the full control word plus State is   |
// |               compared against a hand-written expected word.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mips_control_unit;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic [5:0] Opcode = 6'h00;
   logic [5:0] Funct = 6'h00;
   logic       ALU_zero = 1'b0;
   logic       ALU_overflow = 1'b0;
   logic       PC_load, IorD, wr, MemtoReg, IR_load, MDR_load, RegWrite, RegDst;
   logic       ALUSrcA, A_load, B_load, ALUOut_load, EPC_load;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALU_sel;
   logic [3:0] State;

   int n_cmp = 0;
   int n_bad = 0;

   mips_control_unit #(.MEM_WAIT(1)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct),
      .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
      .PC_load(PC_load), .IorD(IorD), .wr(wr), .MemtoReg(MemtoReg),
      .IR_load(IR_load), .MDR_load(MDR_load), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_sel(ALU_sel), .PCSource(PCSource),
      .A_load(A_load), .B_load(B_load), .ALUOut_load(ALUOut_load),
      .EPC_load(EPC_load), .State(State)
   );

   always #5 Clk = ~Clk;

   // Control word layout:
   // {State[3:0], PC_load, IorD, wr, MemtoReg, IR_load, MDR_load, RegWrite,
   //  RegDst, ALUSrcA, ALUSrcB[1:0], ALU_sel[2:0], PCSource[1:0],
   //  A_load, B_load, ALUOut_load, EPC_load}
   logic [23:0] obs;
   assign obs = {State, PC_load, IorD, wr, MemtoReg, IR_load, MDR_load, RegWrite,
                 RegDst, ALUSrcA, ALUSrcB, ALU_sel, PCSource,
                 A_load, B_load, ALUOut_load, EPC_load};

   localparam logic [23:0] E_RST    = 24'h000000;
   localparam logic [23:0] E_FETCH0 = {4'd1,  9'b0_0_0_0_0_0_0_0_0, 2'b01, 3'b001, 2'b00, 4'b0000};
   localparam logic [23:0] E_FETCH1 = {4'd1,  9'b1_0_0_0_1_0_0_0_0, 2'b01, 3'b001, 2'b00, 4'b0000};
   localparam logic [23:0] E_DECODE = {4'd2,  9'b0_0_0_0_0_0_0_0_0, 2'b11, 3'b001, 2'b00, 4'b1110};
   localparam logic [23:0] E_RSUB   = {4'd3,  9'b0_0_0_0_0_0_0_0_1, 2'b00, 3'b010, 2'b00, 4'b0010};
   localparam logic [23:0] E_RWB    = {4'd4,  9'b0_0_0_0_0_0_1_1_0, 2'b00, 3'b000, 2'b00, 4'b0000};
   localparam logic [23:0] E_MADDR  = {4'd5,  9'b0_0_0_0_0_0_0_0_1, 2'b10, 3'b001, 2'b00, 4'b0010};
   localparam logic [23:0] E_MRD0   = {4'd6,  9'b0_1_0_0_0_0_0_0_0, 2'b00, 3'b000, 2'b00, 4'b0000};
   localparam logic [23:0] E_MRD1   = {4'd6,  9'b0_1_0_0_0_1_0_0_0, 2'b00, 3'b000, 2'b00, 4'b0000};
   localparam logic [23:0] E_LWB    = {4'd7,  9'b0_0_0_1_0_0_1_0_0, 2'b00, 3'b000, 2'b00, 4'b0000};
   localparam logic [23:0] E_MWR    = {4'd8,  9'b0_1_1_0_0_0_0_0_0, 2'b00, 3'b000, 2'b00, 4'b0000};
   localparam logic [23:0] E_BR_T   = {4'd9,  9'b1_0_0_0_0_0_0_0_1, 2'b00, 3'b010, 2'b01, 4'b0000};
   localparam logic [23:0] E_BR_N   = {4'd9,  9'b0_0_0_0_0_0_0_0_1, 2'b00, 3'b010, 2'b01, 4'b0000};
   localparam logic [23:0] E_JMP    = {4'd10, 9'b1_0_0_0_0_0_0_0_0, 2'b00, 3'b000, 2'b10, 4'b0000};
   localparam logic [23:0] E_AEX    = {4'd11, 9'b0_0_0_0_0_0_0_0_1, 2'b10, 3'b001, 2'b00, 4'b0010};
   localparam logic [23:0] E_AWB    = {4'd12, 9'b0_0_0_0_0_0_1_0_0, 2'b00, 3'b000, 2'b00, 4'b0000};
   localparam logic [23:0] E_INV    = {4'd13, 20'h00000};
`ifdef MIPS_CTRL_EXCEPTION_EN
   localparam logic [23:0] E_EXC    = {4'd14, 9'b1_0_0_0_0_0_0_0_0, 2'b01, 3'b010, 2'b11, 4'b0001};
`endif

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (obs !== E_RST) begin
            n_bad++;
            $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, E_RST);
         end
      end
      Reset_n = 1'b1;
      step();
      n_cmp++;
      if (obs !== E_FETCH0) begin
         n_bad++;
         $display("FAIL reset_release: got %h want %h", obs, E_FETCH0);
      end
   endtask

   task automatic test_r_type();
      logic [23:0] seq[$];
      Opcode = 6'h00; Funct = 6'h22;
      seq = '{E_FETCH1, E_DECODE, E_RSUB, E_RWB, E_FETCH0};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL r_sub step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_load();
      logic [23:0] seq[$];
      Opcode = 6'h23;
      seq = '{E_FETCH1, E_DECODE, E_MADDR, E_MRD0, E_MRD1, E_LWB, E_FETCH0};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL lw step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_store();
      logic [23:0] seq[$];
      Opcode = 6'h2B;
      seq = '{E_FETCH1, E_DECODE, E_MADDR, E_MWR, E_FETCH0};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL sw step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [23:0] seq[$];
      ALU_zero = 1'b1;
      Opcode = 6'h04;
      seq = '{E_FETCH1, E_DECODE, E_BR_T, E_FETCH0};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL beq_taken step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
      Opcode = 6'h05;
      seq = '{E_FETCH1, E_DECODE, E_BR_N, E_FETCH0};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL bne_not_taken step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
      // bne with a non-zero result: PC_load follows ALU_zero combinationally
      Opcode = 6'h05;
      seq = '{E_FETCH1, E_DECODE};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL bne_taken step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
      step();
      ALU_zero = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_BR_T) begin
         n_bad++;
         $display("FAIL bne_taken branch: got %h want %h", obs, E_BR_T);
      end
      step();
      n_cmp++;
      if (obs !== E_FETCH0) begin
         n_bad++;
         $display("FAIL bne_taken return: got %h want %h", obs, E_FETCH0);
      end
   endtask

   task automatic test_jump();
      logic [23:0] seq[$];
      Opcode = 6'h02;
      seq = '{E_FETCH1, E_DECODE, E_JMP, E_FETCH0};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL jump step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] seq[$];
      // addi without overflow, immediately followed by an overflowing addi
      Opcode = 6'h08; ALU_overflow = 1'b0;
      seq = '{E_FETCH1, E_DECODE, E_AEX, E_AWB, E_FETCH0};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL addi step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
      ALU_overflow = 1'b1;
`ifdef MIPS_CTRL_EXCEPTION_EN
      seq = '{E_FETCH1, E_DECODE, E_AEX, E_EXC, E_FETCH0};
`else
      seq = '{E_FETCH1, E_DECODE, E_AEX, E_AWB, E_FETCH0};
`endif
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL addi_ovf step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
      ALU_overflow = 1'b0;
   endtask

   task automatic test_invalid();
      logic [23:0] seq[$];
      Opcode = 6'h3F;
`ifdef MIPS_CTRL_EXCEPTION_EN
      seq = '{E_FETCH1, E_DECODE, E_INV, E_EXC, E_FETCH0};
`else
      seq = '{E_FETCH1, E_DECODE, E_INV, E_FETCH0};
`endif
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL invalid step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [23:0] seq[$];
      Opcode = 6'h2B;
      seq = '{E_FETCH1, E_DECODE, E_MADDR, E_MWR};
      foreach (seq[i]) begin
         step();
         n_cmp++;
         if (obs !== seq[i]) begin
            n_bad++;
            $display("FAIL sw_abort step%0d: got %h want %h", i, obs, seq[i]);
         end
      end
      // Drop reset mid-cycle, well away from any clock edge
      #1 Reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_RST) begin
         n_bad++;
         $display("FAIL sw_abort_async: got %h want %h", obs, E_RST);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (obs !== E_RST) begin
            n_bad++;
            $display("FAIL sw_abort_hold cyc%0d: got %h want %h", i, obs, E_RST);
         end
      end
      Reset_n = 1'b1;
      step();
      n_cmp++;
      if (obs !== E_FETCH0) begin
         n_bad++;
         $display("FAIL sw_abort_restart: got %h want %h", obs, E_FETCH0);
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load();
      test_store();
      test_branch();
      test_jump();
      test_back_to_back();
      test_invalid();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
